// File: rtl/bus_wait_ctl.sv
// Memory-side bus controller: zero-wait fast port plus a req/ack bridge for the slow region, stalling the CPU via RDY.
// Optional access timeout with sticky bus_err is enabled by defining BUS_TIMEOUT_EN.
module bus_wait_ctl #(
    parameter logic [7:0] SLOW_BASE = 8'hC0,
    parameter int         TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AD,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_we,
    output logic        ext_req,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        slow_hit;
    logic        timeout_hit;
    logic [15:0] ext_addr_reg;
    logic [7:0]  ext_wdata_reg;
    logic        ext_we_reg;
    logic        ext_req_reg;
    logic [7:0]  rdata_q_reg;
    logic        sel_slow_reg;

    assign slow_hit  = (AD[15:8] >= SLOW_BASE);
    assign mem_addr  = AD;
    assign mem_wdata = DO;
    assign mem_we    = WE & ~slow_hit;
    // The DONE cycle is the one where the CPU is allowed to complete the slow access.
    assign RDY       = ~(slow_hit & (state_reg != S_DONE));
    assign DI        = sel_slow_reg ? rdata_q_reg : mem_rdata;

    assign ext_addr  = ext_addr_reg;
    assign ext_wdata = ext_wdata_reg;
    assign ext_we    = ext_we_reg;
    assign ext_req   = ext_req_reg;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_reg;
    logic       bus_err_reg;

    assign timeout_hit = (cnt_reg == CNT_LAST);
    assign bus_err     = bus_err_reg;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt_reg     <= 8'd0;
            bus_err_reg <= 1'b0;
        end else begin
            if ((state_reg == S_WAIT) && !ext_ack) begin
                cnt_reg <= cnt_reg + 8'd1;
            end else begin
                cnt_reg <= 8'd0;
            end
            // Ack in the same cycle as the timeout wins and leaves bus_err alone.
            if ((state_reg == S_WAIT) && !ext_ack && timeout_hit) begin
                bus_err_reg <= 1'b1;
            end
        end
    end
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign bus_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (slow_hit) state_next = S_WAIT;
            S_WAIT: if (ext_ack || timeout_hit) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ext_addr_reg  <= 16'h0000;
            ext_wdata_reg <= 8'h00;
            ext_we_reg    <= 1'b0;
            ext_req_reg   <= 1'b0;
            rdata_q_reg   <= 8'h00;
            sel_slow_reg  <= 1'b0;
        end else begin
            sel_slow_reg <= (state_reg == S_DONE);
            case (state_reg)
                S_IDLE: begin
                    if (slow_hit) begin
                        ext_addr_reg  <= AD;
                        ext_wdata_reg <= DO;
                        ext_we_reg    <= WE;
                        ext_req_reg   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ext_ack) begin
                        if (!ext_we_reg) begin
                            rdata_q_reg <= ext_rdata;
                        end
                        ext_req_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q_reg <= 8'hFF;
                        ext_req_reg <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_wait_ctl.sv
// Directed testbench for bus_wait_ctl; the timeout scenario runs only when BUS_TIMEOUT_EN is defined.
module tb_bus_wait_ctl;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI;
    logic        RDY;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_we;
    logic        ext_req;
    logic        ext_ack;
    logic [7:0]  ext_rdata;
    logic        bus_err;

    int tests_run    = 0;
    int tests_failed = 0;

    bus_wait_ctl #(.SLOW_BASE(8'hC0), .TIMEOUT(4)) dut (
        .clk(clk), .RST(RST), .AD(AD), .DO(DO), .WE(WE), .DI(DI), .RDY(RDY),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_req(ext_req),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Runs one slow access from its IDLE-hit cycle to DONE, acking on WAIT cycle ack_at (0-based, -1 = never).
    // Returns one cycle after DONE with next_a on the bus; it only collects observations.
    task automatic do_slow(input logic [15:0] a, input logic [7:0] d, input logic w, input int ack_at,
                           input logic [7:0] rd, input logic [15:0] next_a,
                           output int stalls, output int reqs, output logic [15:0] cap_addr,
                           output logic [7:0] cap_wdata, output logic cap_we, output logic cap_mem_we);
        int   waitn;
        logic prev_req;
        waitn = 0; prev_req = 1'b0; stalls = 0; reqs = 0;
        cap_addr = 16'h0; cap_wdata = 8'h0; cap_we = 1'b0; cap_mem_we = 1'b0;
        AD = a; DO = d; WE = w;
        for (int i = 0; i < 300; i++) begin
            ext_ack   = ext_req && (ack_at >= 0) && (waitn == ack_at);
            ext_rdata = ext_ack ? rd : 8'h00;
            #1;
            if (mem_we) cap_mem_we = 1'b1;
            if (ext_req && !prev_req) reqs++;
            if (ext_req) begin
                cap_addr = ext_addr; cap_wdata = ext_wdata; cap_we = ext_we;
            end
            prev_req = ext_req;
            if (RDY) break;
            stalls++;
            if (ext_req) waitn++;
            @(posedge clk); #1;
        end
        ext_ack = 1'b0;
        @(posedge clk); #1;
        AD = next_a; DO = 8'h00; WE = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; AD = 16'hC000; DO = 8'h00; WE = 1'b0;
        ext_ack = 1'b0; ext_rdata = 8'h00; mem_rdata = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (RDY !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy_slow got %b want 0", RDY); end
        AD = 16'h0000; #1;
        tests_run++;
        if (RDY !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy_fast got %b want 1", RDY); end
        tests_run++;
        if ({ext_req, ext_we, ext_addr, ext_wdata, bus_err} !== 27'h0) begin
            tests_failed++;
            $display("FAIL reset_ext got req=%b we=%b addr=%h wdata=%h err=%b want all 0",
                     ext_req, ext_we, ext_addr, ext_wdata, bus_err);
        end
        tests_run++;
        if (DI !== 8'h77) begin tests_failed++; $display("FAIL reset_di got %h want 77", DI); end
        @(posedge clk); #1;
        RST = 1'b0;
    endtask

    task automatic test_fast_write();
        AD = 16'h0200; DO = 8'h5A; WE = 1'b1; #1;
        tests_run++;
        if ({mem_we, mem_wdata, mem_addr, RDY} !== {1'b1, 8'h5A, 16'h0200, 1'b1}) begin
            tests_failed++;
            $display("FAIL fast_write got we=%b wdata=%h addr=%h rdy=%b want 1 5a 0200 1",
                     mem_we, mem_wdata, mem_addr, RDY);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({ext_req, RDY} !== 2'b01) begin
            tests_failed++;
            $display("FAIL fast_write_noreq got req=%b rdy=%b want 0 1", ext_req, RDY);
        end
        tests_run++;
        if (DI !== 8'h77) begin tests_failed++; $display("FAIL fast_di got %h want 77", DI); end
        AD = 16'h0000; DO = 8'h00; WE = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_slow_read();
        int st, rq; logic [15:0] ca; logic [7:0] cw; logic cwe, cmw;
        do_slow(16'hC010, 8'h00, 1'b0, 2, 8'h3C, 16'h0100, st, rq, ca, cw, cwe, cmw);
        #1;
        tests_run++;
        if (st !== 4) begin tests_failed++; $display("FAIL read_stalls got %0d want 4", st); end
        tests_run++;
        if ({rq, ca, cwe} !== {32'd1, 16'hC010, 1'b0}) begin
            tests_failed++;
            $display("FAIL read_ext got reqs=%0d addr=%h we=%b want 1 c010 0", rq, ca, cwe);
        end
        tests_run++;
        if (DI !== 8'h3C) begin tests_failed++; $display("FAIL read_di got %h want 3c", DI); end
        tests_run++;
        if ({ext_req, RDY} !== 2'b01) begin
            tests_failed++;
            $display("FAIL read_after got req=%b rdy=%b want 0 1", ext_req, RDY);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_slow_write();
        int st, rq; logic [15:0] ca; logic [7:0] cw; logic cwe, cmw;
        do_slow(16'hFF00, 8'hA5, 1'b1, 0, 8'h99, 16'h0000, st, rq, ca, cw, cwe, cmw);
        #1;
        tests_run++;
        if (st !== 2) begin tests_failed++; $display("FAIL write_stalls got %0d want 2", st); end
        tests_run++;
        if ({rq, ca, cw, cwe, cmw} !== {32'd1, 16'hFF00, 8'hA5, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL write_ext got reqs=%0d addr=%h wdata=%h we=%b mem_we=%b want 1 ff00 a5 1 0",
                     rq, ca, cw, cwe, cmw);
        end
        // A write must leave the previously read data in place.
        tests_run++;
        if (DI !== 8'h3C) begin tests_failed++; $display("FAIL write_keeps_rdata got %h want 3c", DI); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int st, rq; logic [15:0] ca; logic [7:0] cw; logic cwe, cmw;
        do_slow(16'hC000, 8'h00, 1'b0, 0, 8'h11, 16'hC001, st, rq, ca, cw, cwe, cmw);
        #1;
        tests_run++;
        if ({DI, RDY} !== {8'h11, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_first got di=%h rdy=%b want 11 0", DI, RDY);
        end
        tests_run++;
        if ({rq, ca} !== {32'd1, 16'hC000}) begin
            tests_failed++;
            $display("FAIL b2b_req1 got reqs=%0d addr=%h want 1 c000", rq, ca);
        end
        do_slow(16'hC001, 8'h00, 1'b0, 1, 8'h22, 16'h0000, st, rq, ca, cw, cwe, cmw);
        #1;
        tests_run++;
        if (DI !== 8'h22) begin tests_failed++; $display("FAIL b2b_second got di=%h want 22", DI); end
        tests_run++;
        if ({rq, ca, st} !== {32'd1, 16'hC001, 32'd3}) begin
            tests_failed++;
            $display("FAIL b2b_req2 got reqs=%0d addr=%h stalls=%0d want 1 c001 3", rq, ca, st);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_wait();
        int st, rq; logic [15:0] ca; logic [7:0] cw; logic cwe, cmw;
        AD = 16'hC123; DO = 8'h00; WE = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({ext_req, RDY} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_pre got req=%b rdy=%b want 1 0", ext_req, RDY);
        end
        RST = 1'b1; #1;
        tests_run++;
        if ({ext_req, ext_addr, bus_err} !== 18'h0) begin
            tests_failed++;
            $display("FAIL rst_mid got req=%b addr=%h err=%b want 0 0000 0", ext_req, ext_addr, bus_err);
        end
        AD = 16'h0000; #1;
        RST = 1'b0;
        @(posedge clk); #1;
        do_slow(16'hC200, 8'h00, 1'b0, 1, 8'h5C, 16'h0000, st, rq, ca, cw, cwe, cmw);
        #1;
        tests_run++;
        if ({rq, ca, st, DI} !== {32'd1, 16'hC200, 32'd3, 8'h5C}) begin
            tests_failed++;
            $display("FAIL rst_clean got reqs=%0d addr=%h stalls=%0d di=%h want 1 c200 3 5c", rq, ca, st, DI);
        end
        @(posedge clk); #1;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        int st, rq; logic [15:0] ca; logic [7:0] cw; logic cwe, cmw;
        do_slow(16'hD000, 8'h00, 1'b0, -1, 8'h00, 16'h0000, st, rq, ca, cw, cwe, cmw);
        #1;
        tests_run++;
        if ({st, DI, bus_err, ext_req} !== {32'd5, 8'hFF, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout got stalls=%0d di=%h err=%b req=%b want 5 ff 1 0", st, DI, bus_err, ext_req);
        end
        do_slow(16'hC050, 8'h00, 1'b0, 0, 8'h42, 16'h0000, st, rq, ca, cw, cwe, cmw);
        #1;
        tests_run++;
        if ({DI, bus_err} !== {8'h42, 1'b1}) begin
            tests_failed++;
            $display("FAIL timeout_sticky got di=%h err=%b want 42 1", DI, bus_err);
        end
        RST = 1'b1; #1;
        tests_run++;
        if (bus_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_clear got %b want 0", bus_err); end
        @(posedge clk); #1;
        RST = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_final_err();
        tests_run++;
        if (bus_err !== 1'b0) begin tests_failed++; $display("FAIL final_err got %b want 0", bus_err); end
    endtask

    initial begin
        test_reset();
        test_fast_write();
        test_slow_read();
        test_slow_write();
        test_back_to_back();
        test_rst_mid_wait();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_final_err();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
